// File: rtl/rv32i_arb_pkg.sv
// Shared types and widths for the RV32I data-memory arbiter.
package rv32i_arb_pkg;

    localparam int BE_W   = 4;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/rv32i_starve_cnt.sv
// Saturating starvation counter with synchronous clear.
// Counts cycles a pending debug request is denied; at_limit tells the
// arbiter to force a debug grant. Clear has priority over increment.
module rv32i_starve_cnt #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Saturating up-count, cleared on request or when debug is served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit = (count >= LIMIT);

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// Data-port arbiter between the core MEM stage and a debug/loader port.
//
// Handshake: a requester presents *_req with its fields and holds them
// stable until accepted. The core is accepted on any cycle where
// core_req=1 and core_stall=0; debug is accepted on the cycle dbg_gnt=1.
// Acceptance is combinational in the same cycle. A read accepted in
// cycle N returns exactly one cycle later with *_rvalid=1 for one cycle;
// there is no back-pressure on read data.
//
// fsm_state and starve_level are observability outputs for checkers.
module rv32i_dmem_arbiter
    import rv32i_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    // core MEM stage
    input  logic              core_req,
    input  logic              core_we,
    input  logic [BE_W-1:0]   core_be,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    // debug / loader
    input  logic              dbg_halt,
    output logic              dbg_halted,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [BE_W-1:0]   dbg_be,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    // RAM data port
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // observability
    output arb_state_t        fsm_state,
    output logic [CNT_W-1:0]  starve_level
);

    arb_state_t state;
    arb_owner_t rd_owner;
    logic       rd_pending;
    logic       core_sel;
    logic       dbg_sel;
    logic       force_dbg;
    logic       at_limit;
    logic       cnt_inc;
    logic       cnt_clr;

    assign force_dbg = dbg_req && at_limit;

    // Same-cycle grant; nothing is granted while reset is held low.
    always_comb begin
        core_sel = 1'b0;
        dbg_sel  = 1'b0;
        if (reset) begin
            if (state == HALT) begin
                dbg_sel = dbg_req;
            end else if (core_req && !force_dbg) begin
                core_sel = 1'b1;
            end else begin
                dbg_sel = dbg_req;
            end
        end
    end

    assign dbg_gnt    = dbg_sel;
    assign core_stall = reset && ((state == HALT) || (core_req && !core_sel));

    // Route the granted requester onto the RAM port; idle port drives zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_sel) begin
            mem_we    = core_we;
            mem_be    = core_be;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dbg_sel) begin
            mem_we    = dbg_we;
            mem_be    = dbg_be;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // RUN/HALT state and read-return tracking; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CORE;
        end else begin
            case (state)
                RUN:     if (dbg_halt)  state <= HALT;
                HALT:    if (!dbg_halt) state <= RUN;
                default: state <= RUN;
            endcase
            rd_pending <= (core_sel && !core_we) || (dbg_sel && !dbg_we);
            if (core_sel || dbg_sel) begin
                rd_owner <= dbg_sel ? OWN_DBG : OWN_CORE;
            end
        end
    end

    assign dbg_halted = (state == HALT);
    assign fsm_state  = state;

    // Read data goes only to the requester that issued the read.
    assign core_rvalid = rd_pending && (rd_owner == OWN_CORE);
    assign dbg_rvalid  = rd_pending && (rd_owner == OWN_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;

    // In RUN the counter tracks denied debug cycles; in HALT it holds
    // and is cleared on the edge that leaves HALT.
    assign cnt_inc = (state == RUN) && dbg_req && core_sel;
    assign cnt_clr = (state == RUN) ? (dbg_sel || !dbg_req) : !dbg_halt;

    rv32i_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .count    (starve_level),
        .at_limit (at_limit)
    );

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Bench for rv32i_dmem_arbiter: sync RAM model on the data port, a
// behavioural reference checked every cycle, and directed scenarios.
module tb_rv32i_dmem_arbiter;
  import rv32i_arb_pkg::*;

  localparam int LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        core_req, core_we, core_stall, core_rvalid;
  logic [3:0]  core_be;
  logic [29:0] core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        dbg_halt, dbg_halted, dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [3:0]  dbg_be;
  logic [29:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  arb_state_t  fsm_state;
  logic [3:0]  starve_level;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_stall(core_stall),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .dbg_halt(dbg_halt), .dbg_halted(dbg_halted), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state), .starve_level(starve_level)
  );

  // ---------------- environment RAM (driven by DUT mem_* port) ----------------
  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic [32:0] exp_q[$];   // {owner_is_dbg, data} for reads awaiting return

  initial begin : compare_proc
    bit          m_halted;
    int          m_cnt;
    bit          in_rst, c, d, frc;
    bit          e_we, e_stall, e_cv, e_dv;
    logic [3:0]  e_be;
    logic [29:0] e_addr;
    logic [31:0] e_wdata, e_cd, e_dd;
    logic [32:0] e;
    bit          n_halted;
    int          n_cnt;
    m_halted = 0;
    m_cnt    = 0;
    forever begin
      @(negedge clk);
      in_rst = !reset;
      c = 0; d = 0; n_halted = 0; n_cnt = 0;
      e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
      if (in_rst) begin
        m_halted = 0;
        m_cnt    = 0;
        exp_q.delete();
        check("rst_core_stall", 32'(core_stall), 0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 0);
        check("rst_dbg_halted", 32'(dbg_halted), 0);
        check("rst_core_rvalid", 32'(core_rvalid), 0);
        check("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
      end else begin
        // who gets the port this cycle
        if (m_halted) begin
          d = dbg_req;
        end else begin
          frc = dbg_req && (m_cnt >= LIMIT);
          c = core_req && !frc;
          d = dbg_req && !c;
        end
        e_stall = m_halted || (core_req && !c);
        if (c) begin
          e_we = core_we; e_be = core_be; e_addr = core_addr; e_wdata = core_wdata;
        end else if (d) begin
          e_we = dbg_we; e_be = dbg_be; e_addr = dbg_addr; e_wdata = dbg_wdata;
        end
        // read issued last cycle comes back now
        e_cv = 0; e_dv = 0; e_cd = 0; e_dd = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e[32]) begin e_dv = 1; e_dd = e[31:0]; end
          else       begin e_cv = 1; e_cd = e[31:0]; end
        end
        check("core_stall", 32'(core_stall), 32'(e_stall));
        check("dbg_gnt", 32'(dbg_gnt), 32'(d));
        check("dbg_halted", 32'(dbg_halted), 32'(m_halted));
        check("fsm_state", 32'(fsm_state), 32'(m_halted));
        check("starve_level", 32'(starve_level), 32'(m_cnt));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_be", 32'(mem_be), 32'(e_be));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", mem_wdata, e_wdata);
        check("core_rvalid", 32'(core_rvalid), 32'(e_cv));
        check("core_rdata", core_rdata, e_cd);
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(e_dv));
        check("dbg_rdata", dbg_rdata, e_dd);
        // next model state
        n_halted = dbg_halt;
        if (!m_halted) begin
          if (d || !dbg_req) n_cnt = 0;
          else if (c)        n_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
          else               n_cnt = m_cnt;
        end else begin
          n_cnt = dbg_halt ? m_cnt : 0;
        end
      end
      @(posedge clk);
      if (!in_rst && reset) begin
        if ((c || d) && !e_we) exp_q.push_back({d, ref_mem[e_addr[7:0]]});
        if ((c || d) && e_we) begin
          for (int b = 0; b < 4; b++)
            if (e_be[b]) ref_mem[e_addr[7:0]][8*b +: 8] = e_wdata[8*b +: 8];
        end
        m_halted = n_halted;
        m_cnt    = n_cnt;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_be = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic core_read(input logic [29:0] a);
    core_req = 1; core_we = 0; core_be = 4'hF; core_addr = a; core_wdata = 0;
  endtask

  task automatic dbg_read(input logic [29:0] a);
    dbg_req = 1; dbg_we = 0; dbg_be = 4'hF; dbg_addr = a; dbg_wdata = 0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 0; ref_mem[i] = 0; end
    ram[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      ram[8'h30 + i] = 32'h1000_0000 + i;
      ref_mem[8'h30 + i] = 32'h1000_0000 + i;
    end
    reset = 0; dbg_halt = 0;
    idle();
    // requests presented during reset must be ignored
    core_read(30'h10);
    dbg_read(30'h12);
    @(negedge clk);
    check("lit_rst_stall", 32'(core_stall), 0);
    check("lit_rst_addr", 32'(mem_addr), 0);
    tick(); tick();
    idle();
    reset = 1;
    @(negedge clk);
    check("lit_after_rst_state", 32'(fsm_state), 0);
    tick();

    // core read only
    core_read(30'h10);
    @(negedge clk);
    check("lit_core_rd_stall", 32'(core_stall), 0);
    tick();
    idle();
    @(negedge clk);
    check("lit_core_rvalid", 32'(core_rvalid), 1);
    check("lit_core_rdata", core_rdata, 32'hDEADBEEF);
    check("lit_core_rd_dbg_rvalid", 32'(dbg_rvalid), 0);
    tick();

    // contention: debug forced every 9th cycle
    core_read(30'h11);
    dbg_read(30'h12);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      check($sformatf("lit_cont_gnt_%0d", i), 32'(dbg_gnt), (i % 9 == 0) ? 1 : 0);
      check($sformatf("lit_cont_stall_%0d", i), 32'(core_stall), (i % 9 == 0) ? 1 : 0);
      tick();
    end
    idle();
    tick();

    // debug write while core idle, then core reads it back
    dbg_req = 1; dbg_we = 1; dbg_be = 4'b0011; dbg_addr = 30'h20; dbg_wdata = 32'h1234ABCD;
    @(negedge clk);
    check("lit_dw_gnt", 32'(dbg_gnt), 1);
    check("lit_dw_we", 32'(mem_we), 1);
    check("lit_dw_be", 32'(mem_be), 32'h3);
    tick();
    idle();
    tick();
    core_read(30'h20);
    tick();
    idle();
    @(negedge clk);
    check("lit_dw_readback", core_rdata, 32'h0000ABCD);
    tick();

    // HALT entry while both request: this cycle is still RUN arbitration
    core_read(30'h10);
    dbg_read(30'h30);
    dbg_halt = 1;
    @(negedge clk);
    check("lit_h0_dbg_gnt", 32'(dbg_gnt), 0);
    check("lit_h0_stall", 32'(core_stall), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      dbg_read(30'h30 + 30'(i));
      @(negedge clk);
      check("lit_h_halted", 32'(dbg_halted), 1);
      check("lit_h_stall", 32'(core_stall), 1);
      check("lit_h_gnt", 32'(dbg_gnt), 1);
      if (i == 0) begin
        check("lit_h_last_run_rvalid", 32'(core_rvalid), 1);
        check("lit_h_last_run_rdata", core_rdata, 32'hDEADBEEF);
      end else begin
        check("lit_h_dbg_rvalid", 32'(dbg_rvalid), 1);
        check("lit_h_dbg_rdata", dbg_rdata, 32'h1000_0000 + i - 1);
      end
      tick();
    end
    dbg_req = 0;
    dbg_halt = 0;
    @(negedge clk);
    check("lit_hx_halted", 32'(dbg_halted), 1);
    check("lit_hx_stall", 32'(core_stall), 1);
    check("lit_hx_dbg_rdata", dbg_rdata, 32'h1000_0003);
    tick();
    @(negedge clk);
    check("lit_run_halted", 32'(dbg_halted), 0);
    check("lit_run_stall", 32'(core_stall), 0);
    check("lit_run_addr", 32'(mem_addr), 32'h10);
    tick();
    idle();
    tick();

    // reset while a core read is in flight
    core_read(30'h10);
    @(negedge clk);
    check("lit_mr_stall", 32'(core_stall), 0);
    tick();
    reset = 0;
    @(negedge clk);
    check("lit_mr_rvalid", 32'(core_rvalid), 0);
    check("lit_mr_rdata", core_rdata, 0);
    tick();
    idle();
    reset = 1;
    @(negedge clk);
    check("lit_mr_state", 32'(fsm_state), 0);
    check("lit_mr_cnt", 32'(starve_level), 0);
    check("lit_mr_rvalid2", 32'(core_rvalid), 0);
    tick();

    // read return ordering: debug then core
    dbg_read(30'h31);
    @(negedge clk);
    check("lit_ord_gnt", 32'(dbg_gnt), 1);
    tick();
    idle();
    core_read(30'h10);
    @(negedge clk);
    check("lit_ord_dbg_rvalid", 32'(dbg_rvalid), 1);
    check("lit_ord_dbg_rdata", dbg_rdata, 32'h1000_0001);
    check("lit_ord_core_rvalid0", 32'(core_rvalid), 0);
    check("lit_ord_core_rdata0", core_rdata, 0);
    tick();
    idle();
    @(negedge clk);
    check("lit_ord_core_rvalid", 32'(core_rvalid), 1);
    check("lit_ord_core_rdata", core_rdata, 32'hDEADBEEF);
    check("lit_ord_dbg_rvalid0", 32'(dbg_rvalid), 0);
    check("lit_ord_dbg_rdata0", dbg_rdata, 0);
    tick();

    // mixed writes under contention
    core_req = 1; core_we = 1; core_be = 4'b1100; core_addr = 30'h40; core_wdata = 32'hCAFE0000;
    dbg_req = 1; dbg_we = 1; dbg_be = 4'b1111; dbg_addr = 30'h41; dbg_wdata = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) tick();
    idle();
    core_read(30'h41);
    tick();
    core_read(30'h40);
    tick();
    idle();
    @(negedge clk);
    check("lit_mix_core_rdata", core_rdata, 32'hCAFE0000);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_dmem_arbiter.md
Name: rv32i_dmem_arbiter

Overview:
- Shares the single data port of rv32i_syncDualPortRam between two requesters: the core MEM stage (primary) and a debug/loader port (secondary).
- Sits between rv32i_memTop and the RAM data port.
- Provides per-cycle arbitration, a starvation guard for the debug port, a debug HALT mode that takes exclusive ownership of the port, and routing of synchronous read data back to whichever requester issued the read.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles debug may be denied while pending before it is forced a grant. 0 gives debug strict priority.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- core_req  in  1  core access valid this cycle
- core_we  in  1  core write (1) / read (0)
- core_be  in  4  core byte enables
- core_addr  in  30  core word address [31:2]
- core_wdata  in  32  core write data
- core_stall  out  1  core must hold its request stable and freeze
- core_rdata  out  32  read data to core
- core_rvalid  out  1  core read data valid
- dbg_halt  in  1  debug requests exclusive ownership
- dbg_halted  out  1  HALT state active
- dbg_req  in  1  debug access valid
- dbg_we  in  1  debug write/read
- dbg_be  in  4  debug byte enables
- dbg_addr  in  30  debug word address
- dbg_wdata  in  32  debug write data
- dbg_gnt  out  1  debug access accepted this cycle
- dbg_rdata  out  32  read data to debug
- dbg_rvalid  out  1  debug read data valid
- mem_we  out  1  to RAM d_we
- mem_be  out  4  to RAM d_be
- mem_addr  out  30  to RAM d_addr
- mem_wdata  out  32  to RAM d_wdata
- mem_rdata  in  32  from RAM d_rdata (one-cycle latency)

Behaviour:
- Reset (reset low, asynchronous) puts the block in this state:
  - state=RUN, starve_cnt=0, rd_pending=0, rd_owner=CORE.
  - All outputs 0: core_stall, dbg_gnt, dbg_halted, core_rvalid, dbg_rvalid, both rdata outputs, all mem_* outputs.
- A read in flight when reset asserts is dropped; no rvalid is produced after reset releases.
- States:
  - RUN to HALT when dbg_halt is sampled 1 at a clock edge.
  - HALT to RUN when dbg_halt is sampled 0; starve_cnt is cleared on exit.
  - dbg_halted = (state==HALT), registered.
- Grant in RUN is combinational in the same cycle:
  - force_dbg = dbg_req && (starve_cnt >= STARVE_LIMIT).
  - Grant core if core_req && !force_dbg.
  - Otherwise grant debug if dbg_req.
- Grant in HALT: debug is granted whenever dbg_req; the core is never granted.
- core_stall = core_req && !core_granted. In HALT it is held at 1 regardless of core_req.
- dbg_gnt = dbg granted. A debug request is complete on the cycle dbg_gnt=1; debug holds its request until then.
- mem_* carry the granted requester's fields. With no grant: mem_we=0, mem_be=0, mem_addr and mem_wdata hold 0.
- starve_cnt updates at each clock edge in RUN:
  - +1 (saturating at STARVE_LIMIT) when dbg_req && core granted.
  - Cleared when debug is granted or dbg_req=0.
- Read return:
  - A granted read (we=0) sets rd_pending=1 and rd_owner to the grantee at the next edge.
  - In the following cycle the owner's rvalid=1 and its rdata=mem_rdata. The other requester's rdata=0 and rvalid=0.
  - Reads are pipelined: back-to-back reads from either requester produce back-to-back rvalids in grant order.
- Writes produce no rvalid.
- Simultaneous events:
  - dbg_halt rising while both request: the current cycle is still arbitrated under RUN.
  - A read granted on the last RUN cycle returns normally in the first HALT cycle.
- With STARVE_LIMIT=0, debug always wins a contested cycle.

Decomposition:
- Package rv32i_arb_pkg holds:
  - typedef enum {RUN, HALT} arb_state_t
  - typedef enum {OWN_CORE, OWN_DBG} arb_owner_t
  - BE_W=4, ADDR_W=30, DATA_W=32
- One natural sub-module: rv32i_starve_cnt, the saturating counter with clear, parameterised by STARVE_LIMIT and CNT_W.
- Muxing and the FSM stay in the top module.

Test Plan:
- Core read only: core_req=1, we=0, addr=0x10 for 1 cycle, RAM word 0xDEADBEEF.
  - Required: core_stall=0; next cycle core_rvalid=1, core_rdata=0xDEADBEEF; dbg_rvalid=0.
- Contention with STARVE_LIMIT=8: core_req and dbg_req held high continuously.
  - Required: core granted 8 cycles; cycle 9 dbg_gnt=1 and core_stall=1; cycle 10 core is granted again.
- Debug write while core idle: dbg_req=1, we=1, be=4'b0011, addr=0x20, wdata=0x1234ABCD.
  - Required: same cycle dbg_gnt=1, mem_we=1, mem_be=4'b0011.
  - A later core read of 0x20 returns the low halfword 0xABCD.
- HALT: assert dbg_halt with core_req=1.
  - Required: next cycle dbg_halted=1 and core_stall=1.
  - Four debug reads are granted back-to-back, each with dbg_rvalid one cycle later.
  - Drop dbg_halt: next cycle RUN, core_stall=0, core granted.
- Reset mid-read: grant a core read, then assert reset in the next cycle.
  - Required: core_rvalid stays 0 and all outputs are 0 while reset is low.
  - After release: state=RUN, starve_cnt=0.
- Read return ordering: dbg read granted at cycle N, core read at cycle N+1.
  - Required: dbg_rvalid at N+1 and core_rvalid at N+2, each with the correct data; the outputs never cross.
